// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, colour type and ball axis step helper
package vga_pkg;

    localparam int unsigned H_VIS = 640;
    localparam int unsigned V_VIS = 480;

    typedef logic [11:0] rgb_t;

    localparam rgb_t BALL_RGB = 12'hF00;
    localparam rgb_t WALL_RGB = 12'h00F;
    localparam rgb_t BG_RGB   = 12'h000;

    // One axis worth of ball state; dir = 1 means moving towards larger coordinates.
    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
    } axis_t;

    // Advance one axis by one frame, clamping onto the wall and flipping direction on contact.
    // All arithmetic is done in 11 bits so pos + size + speed cannot wrap.
    function automatic axis_t axis_step(
        input logic [9:0]  pos,
        input logic        dir,
        input int unsigned limit,
        input int unsigned size,
        input int unsigned speed,
        input int unsigned wall
    );
        axis_t      res;
        logic [10:0] p;
        p = {1'b0, pos};
        if (dir) begin
            if (p + 11'(size + speed) >= 11'(limit - wall)) begin
                res.pos = 10'(limit - wall - size);
                res.dir = 1'b0;
            end else begin
                res.pos = 10'(p + 11'(speed));
                res.dir = 1'b1;
            end
        end else begin
            if (p <= 11'(wall + speed)) begin
                res.pos = 10'(wall);
                res.dir = 1'b1;
            end else begin
                res.pos = 10'(p - 11'(speed));
                res.dir = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - ball position/direction state, updated once per frame in vertical blank
module ball_motion #(
    parameter int unsigned H_VIS      = 640,
    parameter int unsigned V_VIS      = 480,
    parameter int unsigned BALL_SIZE  = 8,
    parameter int unsigned BALL_SPEED = 2,
    parameter int unsigned WALL_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       pause,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y
);
    import vga_pkg::*;

    logic  dir_x;
    logic  dir_y;
    axis_t nx;
    axis_t ny;

    // Candidate next state for both axes; only committed on an unpaused frame tick.
    always_comb begin
        nx = axis_step(ball_x, dir_x, H_VIS, BALL_SIZE, BALL_SPEED, WALL_W);
        ny = axis_step(ball_y, dir_y, V_VIS, BALL_SIZE, BALL_SPEED, WALL_W);
    end

    // Ball state register: centred and heading down-right after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ball_x <= 10'((H_VIS - BALL_SIZE) / 2);
            ball_y <= 10'((V_VIS - BALL_SIZE) / 2);
            dir_x  <= 1'b1;
            dir_y  <= 1'b1;
        end else if (frame_tick && !pause) begin
            ball_x <= nx.pos;
            dir_x  <= nx.dir;
            ball_y <= ny.pos;
            dir_y  <= ny.dir;
        end
    end

endmodule

// File: rtl/vga_ball_gen.sv
// rtl/vga_ball_gen.sv - bordered playfield with bouncing ball, registered RGB and realigned sync
module vga_ball_gen #(
    parameter int unsigned   H_VIS      = vga_pkg::H_VIS,
    parameter int unsigned   V_VIS      = vga_pkg::V_VIS,
    parameter int unsigned   BALL_SIZE  = 8,
    parameter int unsigned   BALL_SPEED = 2,
    parameter int unsigned   WALL_W     = 4,
    parameter vga_pkg::rgb_t BALL_RGB   = vga_pkg::BALL_RGB,
    parameter vga_pkg::rgb_t WALL_RGB   = vga_pkg::WALL_RGB,
    parameter vga_pkg::rgb_t BG_RGB     = vga_pkg::BG_RGB
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        pause,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync
);
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic        frame_tick;
    logic        ball_on;
    logic        wall_on;
    logic [11:0] rgb_next;
    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] bx;
    logic [10:0] by;

    // First pixel of the first blank line: exactly once per frame, never during visible video.
    assign frame_tick = (pixel_x == 10'd0) && (pixel_y == 10'(V_VIS));

    ball_motion #(
        .H_VIS      (H_VIS),
        .V_VIS      (V_VIS),
        .BALL_SIZE  (BALL_SIZE),
        .BALL_SPEED (BALL_SPEED),
        .WALL_W     (WALL_W)
    ) u_motion (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .pause      (pause),
        .ball_x     (ball_x),
        .ball_y     (ball_y)
    );

    // Classify the current pixel against the ball square and the border, then pick its colour.
    always_comb begin
        px = {1'b0, pixel_x};
        py = {1'b0, pixel_y};
        bx = {1'b0, ball_x};
        by = {1'b0, ball_y};
        ball_on = (px >= bx) && (px < bx + 11'(BALL_SIZE)) &&
                  (py >= by) && (py < by + 11'(BALL_SIZE));
        wall_on = (px < 11'(WALL_W)) || (px >= 11'(H_VIS - WALL_W)) ||
                  (py < 11'(WALL_W)) || (py >= 11'(V_VIS - WALL_W));
        rgb_next = BG_RGB;
        if (!video_on)
            rgb_next = 12'h000;
        else if (ball_on)
            rgb_next = BALL_RGB;
        else if (wall_on)
            rgb_next = WALL_RGB;
    end

    // Output stage: colour and sync share one register so they stay aligned at the DAC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb   <= 12'h000;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else begin
            rgb   <= rgb_next;
            hsync <= hsync_in;
            vsync <= vsync_in;
        end
    end

endmodule

// File: tb/tb_vga_ball_gen.sv
// tb/tb_vga_ball_gen.sv - scoreboard bench for vga_ball_gen
module tb_vga_ball_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync_in;
    logic        vsync_in;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pause;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [13:0] v;
        string       tag;
    } exp_t;
    exp_t sb[$];

    int m_bx, m_by;
    bit m_dx, m_dy;

    always #5 clk = ~clk;

    vga_ball_gen dut (
        .clk      (clk),
        .reset    (reset),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .video_on (video_on),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .pause    (pause),
        .rgb      (rgb),
        .hsync    (hsync),
        .vsync    (vsync)
    );

    function automatic logic [11:0] model_rgb(int x, int y, bit von);
        bit ball, wall;
        if (!von) return 12'h000;
        ball = (x >= m_bx) && (x < m_bx + 8) && (y >= m_by) && (y < m_by + 8);
        wall = (x < 4) || (x >= 636) || (y < 4) || (y >= 476);
        if (ball) return 12'hF00;
        if (wall) return 12'h00F;
        return 12'h000;
    endfunction

    task automatic model_reset();
        m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
    endtask

    task automatic model_tick();
        if (m_dx) begin
            if (m_bx + 10 >= 636) begin m_bx = 628; m_dx = 0; end
            else m_bx = m_bx + 2;
        end else begin
            if (m_bx <= 6) begin m_bx = 4; m_dx = 1; end
            else m_bx = m_bx - 2;
        end
        if (m_dy) begin
            if (m_by + 10 >= 476) begin m_by = 468; m_dy = 0; end
            else m_by = m_by + 2;
        end else begin
            if (m_by <= 6) begin m_by = 4; m_dy = 1; end
            else m_by = m_by - 2;
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            assert ({rgb, hsync, vsync} === e.v) else begin
                n_fail++;
                $error("FAIL %s: observed rgb/hs/vs=%h expected %h", e.tag, {rgb, hsync, vsync}, e.v);
            end
        end
    endtask

    task automatic step(input int x, input int y, input bit von, input bit hs, input bit vs,
                        input bit pz, input string tag);
        exp_t e;
        @(negedge clk);
        check_out();
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        pause    = pz;
        e.v   = {model_rgb(x, y, von), hs, vs};
        e.tag = tag;
        sb.push_back(e);
        if (x == 0 && y == 480 && !pz) model_tick();
    endtask

    task automatic flush();
        @(negedge clk);
        check_out();
    endtask

    task automatic probe_ball(input string tag);
        step(m_bx,     m_by,     1, 0, 0, pause, tag);
        step(m_bx - 1, m_by,     1, 0, 0, pause, tag);
        step(m_bx + 7, m_by + 7, 1, 0, 0, pause, tag);
        step(m_bx + 8, m_by + 7, 1, 0, 0, pause, tag);
        step(m_bx,     m_by - 1, 1, 0, 0, pause, tag);
        step(m_bx + 7, m_by + 8, 1, 0, 0, pause, tag);
    endtask

    task automatic imm_check(input logic [13:0] obs, input logic [13:0] expv, input string tag);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        check_out();
        #2;
        reset = 1'b0;
        #1;
        imm_check({rgb, hsync, vsync}, 14'h0, tag);
        sb.delete();
        model_reset();
        pixel_x = 10'd100;
        repeat (3) @(negedge clk);
        imm_check({rgb, hsync, vsync}, 14'h0, {tag, "_held"});
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; hsync_in = 0; vsync_in = 0; video_on = 0;
        pixel_x = 0; pixel_y = 0; pause = 0;
        model_reset();
        repeat (3) @(negedge clk);
        imm_check({rgb, hsync, vsync}, 14'h0, "reset_state");
        reset = 1'b1;

        step(320, 240, 1, 0, 0, 0, "ball_centre");
        step(2,   240, 1, 0, 0, 0, "left_wall");
        step(100, 240, 1, 0, 0, 0, "background");
        step(320, 240, 0, 0, 0, 0, "blank_on_ball");
        step(637, 2,   1, 1, 0, 0, "hsync_rise_wall");
        step(100, 478, 1, 0, 1, 0, "hsync_fall_vsync_rise");
        step(1000, 900, 0, 1, 1, 0, "out_of_range_blank");
        probe_ball("ball_at_reset");

        // Async reset mid-line while the output is showing the ball.
        step(320, 240, 1, 1, 1, 0, "pre_reset_ball");
        async_reset("async_reset_midline");
        probe_ball("ball_after_reset");

        // One frame tick, then neighbouring blank pixels must not move it.
        step(0, 480, 0, 0, 1, 0, "tick1");
        for (int i = 0; i < 10; i++) step(1, 480, 0, 0, 1, 0, "no_tick_hold");
        probe_ball("ball_after_one_tick");

        // Long run through wall and corner bounces.
        for (int i = 0; i < 420; i++) begin
            step(0, 480, 0, 0, 0, 0, "tick_run");
            if (i % 15 == 14 || (i >= 150 && i <= 160)) probe_ball("ball_run");
        end

        // Pause raised mid-frame freezes motion across several ticks.
        step(200, 100, 1, 0, 0, 1, "pause_midframe");
        for (int i = 0; i < 5; i++) begin
            step(0, 480, 0, 0, 0, 1, "tick_paused");
            step(5, 480, 0, 0, 0, 1, "after_paused_tick");
        end
        probe_ball("ball_paused");
        pause = 1'b0;
        step(0, 480, 0, 0, 0, 0, "tick_unpaused");
        probe_ball("ball_unpaused");

        // Reset while paused brings the ball back to centre.
        pause = 1'b1;
        step(0, 480, 0, 0, 0, 1, "tick_paused2");
        step(m_bx + 3, m_by + 3, 1, 0, 0, 1, "pre_reset_paused");
        async_reset("async_reset_paused");
        pause = 1'b0;
        probe_ball("ball_after_paused_reset");
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
